// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the memory stage.
// Data requests win, a bounded streak counter guarantees fetch progress, one transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_req_valid,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_ready,
  input  logic                    fetch_flush,
  output logic                    fetch_resp_valid,
  output logic [DATA_WIDTH-1:0]   fetch_rdata,
  input  logic                    data_req_valid,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_ready,
  output logic                    data_resp_valid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic {OWNER_FETCH = 1'b0, OWNER_DATA = 1'b1} owner_e;

  state_e              state;
  owner_e              owner;
  logic                drop;
  logic [STREAK_W-1:0] streak;

  logic streak_full;
  logic grant_data;
  logic grant_fetch;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    streak_full = (streak == STREAK_W'(MAX_DATA_STREAK));
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (!reset && state == ST_IDLE) begin
      if (data_req_valid && !(fetch_req_valid && streak_full)) begin
        grant_data = 1'b1;
      end else if (fetch_req_valid) begin
        grant_fetch = 1'b1;
      end
    end
  end

  assign data_ready  = grant_data;
  assign fetch_ready = grant_fetch;

  // NOTE: state and registered outputs use non-blocking assignments only, so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      owner            <= OWNER_FETCH;
      drop             <= 1'b0;
      streak           <= '0;
      mem_req_valid    <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_wstrb        <= '0;
      fetch_resp_valid <= 1'b0;
      fetch_rdata      <= '0;
      data_resp_valid  <= 1'b0;
      data_rdata       <= '0;
    end else begin
      fetch_resp_valid <= 1'b0;
      data_resp_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          if (grant_data) begin
            owner         <= OWNER_DATA;
            mem_req_valid <= 1'b1;
            mem_we        <= data_we;
            mem_addr      <= data_addr;
            mem_wdata     <= data_wdata;
            mem_wstrb     <= data_wstrb;
            state         <= ST_ISSUE;
            if (!fetch_req_valid) begin
              streak <= '0;
            end else if (!streak_full) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (grant_fetch) begin
            owner         <= OWNER_FETCH;
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= fetch_addr;
            mem_wdata     <= '0;
            mem_wstrb     <= STRB_W'(0);
            state         <= ST_ISSUE;
            streak        <= '0;
          end
        end
        ST_ISSUE: begin
          if (owner == OWNER_FETCH && fetch_flush) begin
            drop <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (owner == OWNER_FETCH && fetch_flush) begin
            drop <= 1'b1;
          end
          if (mem_resp_valid) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
            if (owner == OWNER_DATA) begin
              data_resp_valid <= 1'b1;
              data_rdata      <= mem_we ? '0 : mem_rdata;
            end else if (!drop && !fetch_flush) begin
              // A flush landing on the response cycle still discards it.
              fetch_resp_valid <= 1'b1;
              fetch_rdata      <= mem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: priority, streak fairness, latency, stall, flush, reset abort.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after it.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req_valid;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_flush;
  logic          fetch_resp_valid;
  logic [DW-1:0] fetch_rdata;
  logic          data_req_valid;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [SW-1:0] data_wstrb;
  logic          data_ready;
  logic          data_resp_valid;
  logic [DW-1:0] data_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_flush(fetch_flush), .fetch_resp_valid(fetch_resp_valid), .fetch_rdata(fetch_rdata),
    .data_req_valid(data_req_valid), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_ready(data_ready),
    .data_resp_valid(data_resp_valid), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req_valid = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
    data_req_valid  = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    mem_req_ready   = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Entered in the ISSUE cycle; returns in the response-pulse cycle (IDLE).
  task automatic finish_xact(input logic [DW-1:0] rdata);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    fetch_req_valid = 1'b1; data_req_valid = 1'b1; mem_resp_valid = 1'b1;
    tick();
    total++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++; $display("FAIL reset_mem_fields: got %h want 0", {mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    total++;
    if ({fetch_resp_valid, fetch_rdata, data_resp_valid, data_rdata} !== '0) begin
      bad++; $display("FAIL reset_resp: got %h want 0", {fetch_resp_valid, fetch_rdata, data_resp_valid, data_rdata});
    end
    total++;
    if ({fetch_ready, data_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_readies: got %b want 00", {fetch_ready, data_ready});
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    fetch_req_valid = 1'b1; fetch_addr = 32'h40;
    data_req_valid  = 1'b1; data_addr = 32'h300; data_we = 1'b0;
    #1;
    total++;
    if ({data_ready, fetch_ready} !== 2'b10) begin
      bad++; $display("FAIL priority_grant: got {d,f}=%b want 10", {data_ready, fetch_ready});
    end
    tick();
    data_req_valid = 1'b0;
    #1;
    total++;
    if ({mem_req_valid, mem_addr, fetch_ready} !== {1'b1, 32'h300, 1'b0}) begin
      bad++; $display("FAIL priority_issue: got v=%b a=%h fr=%b want v=1 a=300 fr=0", mem_req_valid, mem_addr, fetch_ready);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    string got;
    int    n;
    bit    both;
    got = ""; n = 0; both = 1'b0;
    do_reset();
    fetch_req_valid = 1'b1; fetch_addr = 32'h40;
    data_req_valid  = 1'b1; data_addr = 32'h500;
    mem_req_ready   = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h11;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      #1;
      if (data_ready && fetch_ready) both = 1'b1;
      if (data_ready) begin
        got = {got, "D"}; n++;
      end else if (fetch_ready) begin
        got = {got, "F"}; n++;
      end
      tick();
    end
    total++;
    if (got != "DDDDFDDDDF") begin
      bad++; $display("FAIL streak_order: got %s want DDDDFDDDDF", got);
    end
    total++;
    if (both) begin
      bad++; $display("FAIL streak_one_ready: got both readies high want at most one");
    end
    total++;
    if (dut.streak !== '0) begin
      bad++; $display("FAIL streak_cleared: got %0d want 0", dut.streak);
    end
    idle_inputs();
  endtask

  task automatic test_load_latency();
    do_reset();
    mem_req_ready = 1'b1;
    data_req_valid = 1'b1; data_we = 1'b0; data_addr = 32'h100;
    #1;
    total++;
    if (data_ready !== 1'b1) begin
      bad++; $display("FAIL load_accept: got %b want 1", data_ready);
    end
    tick();
    data_req_valid = 1'b0;
    total++;
    if ({mem_req_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL load_issue: got v=%b we=%b a=%h want 1 0 100", mem_req_valid, mem_we, mem_addr);
    end
    tick();
    total++;
    if ({mem_req_valid, data_resp_valid} !== 2'b00) begin
      bad++; $display("FAIL load_wait: got v=%b rv=%b want 0 0", mem_req_valid, data_resp_valid);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_resp_valid = 1'b0;
    total++;
    if ({data_resp_valid, data_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL load_resp: got rv=%b d=%h want 1 deadbeef", data_resp_valid, data_rdata);
    end
    fetch_req_valid = 1'b1; fetch_addr = 32'h44;
    #1;
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL turnaround_accept: got %b want 1", fetch_ready);
    end
    tick();
    fetch_req_valid = 1'b0;
    total++;
    if ({data_resp_valid, data_rdata, mem_addr, mem_we} !== {1'b0, 32'hDEADBEEF, 32'h44, 1'b0}) begin
      bad++; $display("FAIL load_pulse_end: got rv=%b d=%h a=%h we=%b want 0 deadbeef 44 0", data_resp_valid, data_rdata, mem_addr, mem_we);
    end
    finish_xact(32'h13);
    total++;
    if ({fetch_resp_valid, fetch_rdata, data_resp_valid} !== {1'b1, 32'h13, 1'b0}) begin
      bad++; $display("FAIL fetch_resp: got fv=%b d=%h dv=%b want 1 13 0", fetch_resp_valid, fetch_rdata, data_resp_valid);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    fetch_req_valid = 1'b1; fetch_addr = 32'h40;
    tick();
    fetch_req_valid = 1'b0;
    data_req_valid = 1'b1; data_addr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({mem_req_valid, mem_addr, data_ready, fetch_ready} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
        bad++; $display("FAIL stall_hold_%0d: got v=%b a=%h dr=%b fr=%b want 1 40 0 0", i, mem_req_valid, mem_addr, data_ready, fetch_ready);
      end
      if (i == 3) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: got %b want 0", mem_req_valid);
    end
    mem_resp_valid = 1'b1; mem_rdata = 32'h13;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total++;
    if ({fetch_resp_valid, data_ready} !== 2'b11) begin
      bad++; $display("FAIL stall_done: got fv=%b dr=%b want 1 1", fetch_resp_valid, data_ready);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    fetch_req_valid = 1'b1; fetch_addr = 32'h80;
    tick();
    fetch_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; fetch_flush = 1'b1;
    tick();
    fetch_flush = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    data_req_valid = 1'b1; data_we = 1'b0; data_addr = 32'h700;
    #1;
    total++;
    if (data_ready !== 1'b0) begin
      bad++; $display("FAIL flush_wait_ready: got %b want 0", data_ready);
    end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total++;
    if ({fetch_resp_valid, fetch_rdata, data_ready} !== {1'b0, 32'h0, 1'b1}) begin
      bad++; $display("FAIL flush_drop: got fv=%b d=%h dr=%b want 0 0 1", fetch_resp_valid, fetch_rdata, data_ready);
    end
    tick();
    data_req_valid = 1'b0;
    finish_xact(32'h55);
    total++;
    if ({data_resp_valid, data_rdata} !== {1'b1, 32'h55}) begin
      bad++; $display("FAIL flush_queued_data: got rv=%b d=%h want 1 55", data_resp_valid, data_rdata);
    end
    fetch_req_valid = 1'b1; fetch_addr = 32'h84;
    tick();
    fetch_req_valid = 1'b0;
    finish_xact(32'h77);
    total++;
    if ({fetch_resp_valid, fetch_rdata} !== {1'b1, 32'h77}) begin
      bad++; $display("FAIL flush_drop_cleared: got fv=%b d=%h want 1 77", fetch_resp_valid, fetch_rdata);
    end
    fetch_req_valid = 1'b1; fetch_addr = 32'h88;
    tick();
    fetch_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; fetch_flush = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h99;
    tick();
    fetch_flush = 1'b0; mem_resp_valid = 1'b0;
    total++;
    if ({fetch_resp_valid, fetch_rdata} !== {1'b0, 32'h77}) begin
      bad++; $display("FAIL flush_same_cycle: got fv=%b d=%h want 0 77", fetch_resp_valid, fetch_rdata);
    end
    data_req_valid = 1'b1; data_we = 1'b1; data_addr = 32'h900; data_wdata = 32'hA5A5A5A5; data_wstrb = 4'hF;
    tick();
    data_req_valid = 1'b0; fetch_flush = 1'b1; mem_req_ready = 1'b1;
    tick();
    fetch_flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_resp_valid = 1'b0;
    total++;
    if ({data_resp_valid, data_rdata} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL store_ack_flush_ignored: got rv=%b d=%h want 1 0", data_resp_valid, data_rdata);
    end
    idle_inputs();
  endtask

  // Starts from IDLE with fetch_rdata = 0x77 left by test_flush.
  task automatic test_reset_mid();
    data_req_valid = 1'b1; data_we = 1'b1; data_addr = 32'h200;
    data_wdata = 32'hCAFEF00D; data_wstrb = 4'b0011;
    tick();
    data_req_valid = 1'b0;
    total++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b0011}) begin
      bad++; $display("FAIL store_issue: got v=%b we=%b a=%h d=%h s=%b want 1 1 200 cafef00d 0011", mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1; fetch_req_valid = 1'b1;
    tick();
    total++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, fetch_resp_valid, fetch_rdata, data_resp_valid, data_rdata, fetch_ready, data_ready} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got v=%b we=%b a=%h d=%h s=%b fr=%h fready=%b want all 0", mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, fetch_rdata, fetch_ready);
    end
    reset = 1'b0; fetch_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555AAAA;
    tick();
    mem_resp_valid = 1'b0;
    total++;
    if ({fetch_resp_valid, data_resp_valid, mem_req_valid, data_rdata} !== '0) begin
      bad++; $display("FAIL stale_resp: got fv=%b dv=%b v=%b d=%h want 0 0 0 0", fetch_resp_valid, data_resp_valid, mem_req_valid, data_rdata);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_priority();
    test_back_to_back();
    test_load_latency();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
